// File: rtl/lif_array.sv
// Array of leaky integrate-and-fire neurons sharing one input spike vector.
// Each neuron sums signed weights for the active inputs, subtracts a
// shift-based leak, saturates to [0, 2^V_WIDTH-1] and fires a one-cycle pulse
// when the new potential reaches the shared threshold.
// Optional feature macro: LIF_REFRACTORY_EN adds per-neuron refractory
// counters. Without it, REFRAC is ignored and a neuron may fire every step.
module lif_array #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned N_INPUTS  = 4,
  parameter int unsigned V_WIDTH   = 8,
  parameter int unsigned W_WIDTH   = 4,
  parameter int unsigned REFRAC    = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [N_INPUTS-1:0]                   spike_in,
  input  logic [V_WIDTH-1:0]                    threshold,
  input  logic [2:0]                            leak_shift,
  input  logic                                  cfg_we,
  input  logic [$clog2(N_NEURONS*N_INPUTS)-1:0] cfg_addr,
  input  logic [W_WIDTH-1:0]                    cfg_wdata,
  input  logic [$clog2(N_NEURONS)-1:0]          mon_sel,
  output logic [N_NEURONS-1:0]                  spike_out,
  output logic [V_WIDTH-1:0]                    v_mon
);

  localparam int unsigned NW = N_NEURONS * N_INPUTS;
  // Sum width plus one extra bit so V - L + S never wraps before saturation
  localparam int unsigned SW = V_WIDTH + $clog2(N_INPUTS) + 1;
  localparam int unsigned EW = SW + 1;
  localparam int unsigned RW = 4;

  logic [W_WIDTH-1:0] w_q [NW];
  logic [V_WIDTH-1:0] v_q [N_NEURONS];
  logic [V_WIDTH-1:0] vn  [N_NEURONS];
  logic [N_NEURONS-1:0] fire;
  logic [N_NEURONS-1:0] active;

`ifdef LIF_REFRACTORY_EN
  logic [RW-1:0] r_q [N_NEURONS];

  // A neuron integrates only when its refractory counter has run out
  always_comb begin
    for (int n = 0; n < N_NEURONS; n++) begin
      active[n] = (r_q[n] == '0);
    end
  end

  // Refractory counters: load on fire, count down on each enabled step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < N_NEURONS; n++) r_q[n] <= '0;
    end else if (en) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        if (r_q[n] != '0) begin
          r_q[n] <= r_q[n] - 1'b1;
        end else if (fire[n]) begin
          r_q[n] <= RW'(REFRAC);
        end
      end
    end
  end
`else
  // No refractory period: every neuron integrates on every enabled step
  always_comb begin
    active = '1;
  end
`endif

  // Weighted sum, leak and saturation for every neuron (purely combinational)
  always_comb begin
    logic [EW-1:0]      acc;
    logic [V_WIDTH-1:0] leak;
    acc  = '0;
    leak = '0;
    fire = '0;
    for (int n = 0; n < N_NEURONS; n++) begin
      acc = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        if (spike_in[i]) begin
          acc = acc + {{(EW-W_WIDTH){w_q[n*N_INPUTS+i][W_WIDTH-1]}}, w_q[n*N_INPUTS+i]};
        end
      end
      leak = (leak_shift == 3'd0) ? '0 : (v_q[n] >> leak_shift);
      acc  = acc + {{(EW-V_WIDTH){1'b0}}, v_q[n]} - {{(EW-V_WIDTH){1'b0}}, leak};
      if (acc[EW-1]) begin
        vn[n] = '0;
      end else if (|acc[EW-2:V_WIDTH]) begin
        vn[n] = '1;
      end else begin
        vn[n] = acc[V_WIDTH-1:0];
      end
      fire[n] = (threshold != '0) && (vn[n] >= threshold);
    end
  end

  // Membrane potentials and fire pulses; everything but weights holds when en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < N_NEURONS; n++) v_q[n] <= '0;
      spike_out <= '0;
    end else begin
      for (int n = 0; n < N_NEURONS; n++) begin
        spike_out[n] <= 1'b0;
        if (en && active[n]) begin
          if (fire[n]) begin
            v_q[n]       <= '0;
            spike_out[n] <= 1'b1;
          end else begin
            v_q[n] <= vn[n];
          end
        end
      end
    end
  end

  // Weight table; a same-cycle step already used the old value above
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (cfg_we && (int'(cfg_addr) < int'(NW))) begin
      w_q[cfg_addr] <= cfg_wdata;
    end
  end

  // Monitor register: pre-edge potential of the selected neuron
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_mon <= '0;
    end else if (int'(mon_sel) < int'(N_NEURONS)) begin
      v_mon <= v_q[mon_sel];
    end else begin
      v_mon <= '0;
    end
  end

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array: directed scenarios followed by random
// stimulus, all compared against an integer reference model.
module tb_lif_array;

  localparam int N      = 4;
  localparam int I      = 4;
  localparam int REFRAC = 2;
`ifdef LIF_REFRACTORY_EN
  localparam bit REFR_EN = 1'b1;
`else
  localparam bit REFR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] spike_in;
  logic [7:0] threshold;
  logic [2:0] leak_shift;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [3:0] cfg_wdata;
  logic [1:0] mon_sel;
  logic [3:0] spike_out;
  logic [7:0] v_mon;

  always #5 clk = ~clk;

  lif_array #(
    .N_NEURONS(N),
    .N_INPUTS (I),
    .V_WIDTH  (8),
    .W_WIDTH  (4),
    .REFRAC   (REFRAC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .spike_in  (spike_in),
    .threshold (threshold),
    .leak_shift(leak_shift),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .mon_sel   (mon_sel),
    .spike_out (spike_out),
    .v_mon     (v_mon)
  );

  // Reference model state
  int         m_v [N];
  int         m_r [N];
  int         m_w [N*I];
  logic [3:0] m_spk;
  int         m_mon;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      m_v[n] = 0;
      m_r[n] = 0;
    end
    for (int k = 0; k < N*I; k++) m_w[k] = 0;
    m_spk = '0;
    m_mon = 0;
  endtask

  // One clock edge of the neuron array, computed with plain integer arithmetic
  task automatic model_edge();
    int s, l, vn;
    m_mon = m_v[mon_sel];
    m_spk = '0;
    if (en) begin
      for (int n = 0; n < N; n++) begin
        if (REFR_EN && m_r[n] > 0) begin
          m_r[n] = m_r[n] - 1;
        end else begin
          s = 0;
          for (int i = 0; i < I; i++) if (spike_in[i]) s = s + m_w[n*I+i];
          l  = (leak_shift == 0) ? 0 : m_v[n] / (1 << leak_shift);
          vn = m_v[n] - l + s;
          if (vn < 0) vn = 0;
          if (vn > 255) vn = 255;
          if (threshold != 0 && vn >= int'(threshold)) begin
            m_v[n]   = 0;
            m_r[n]   = REFRAC;
            m_spk[n] = 1'b1;
          end else begin
            m_v[n] = vn;
          end
        end
      end
    end
    if (cfg_we && int'(cfg_addr) < N*I) begin
      m_w[cfg_addr] = (cfg_wdata >= 4'd8) ? int'(cfg_wdata) - 16 : int'(cfg_wdata);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_spike"}, {28'd0, spike_out}, {28'd0, m_spk});
    check({tag, "_vmon"}, {24'd0, v_mon}, m_mon);
  endtask

  task automatic wr(input int addr, input int data);
    en        = 1'b0;
    cfg_we    = 1'b1;
    cfg_addr  = 4'(addr);
    cfg_wdata = 4'(data);
    step("wr");
    cfg_we = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_spike", {28'd0, spike_out}, 32'd0);
    check("rst_vmon", {24'd0, v_mon}, 32'd0);
    #2 rst = 1'b0;
  endtask

  int exp_leak [6] = '{10, 5, 3, 2, 1, 1};
  int e;

  initial begin
    rst = 1'b1; en = 1'b0; spike_in = '0; threshold = '0; leak_shift = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; mon_sel = '0;
    model_reset();
    #6;
    check("init_spike", {28'd0, spike_out}, 32'd0);
    check("init_vmon", {24'd0, v_mon}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fire and refractory on neuron 0
    wr(0, 5);
    threshold = 8'd12; leak_shift = 3'd0; spike_in = 4'b0001; mon_sel = 2'd0; en = 1'b1;
    step("fire1");
    step("fire2");
    check("fire2_v", {24'd0, v_mon}, 32'd5);
    step("fire3");
    check("fire3_spike", {28'd0, spike_out}, 32'd1);
    check("fire3_v", {24'd0, v_mon}, 32'd10);
    step("fire4");
    check("fire4_v", {24'd0, v_mon}, 32'd0);
    step("fire5");
    check("fire5_v", {24'd0, v_mon}, REFR_EN ? 32'd0 : 32'd5);
    step("fire6");
    step("fire7");
    check("fire7_v", {24'd0, v_mon}, REFR_EN ? 32'd5 : 32'd0);

    // Mid-run reset clears potentials and weights
    step("pre_rst");
    do_reset();
    spike_in = 4'b1111; en = 1'b1;
    step("post_rst1");
    step("post_rst2");
    check("post_rst_v", {24'd0, v_mon}, 32'd0);

    // Leak on neuron 1
    do_reset();
    wr(5, 7);
    wr(6, 3);
    threshold = 8'd0; leak_shift = 3'd0; spike_in = 4'b0110; mon_sel = 2'd1; en = 1'b1;
    step("leak_load");
    spike_in = 4'b0000; leak_shift = 3'd1;
    for (int k = 0; k < 6; k++) begin
      step("leak");
      check("leak_v", {24'd0, v_mon}, exp_leak[k]);
    end

    // Saturation at both ends on neurons 2 and 3
    do_reset();
    for (int k = 8; k < 12; k++) wr(k, 8);
    for (int k = 12; k < 16; k++) wr(k, 7);
    threshold = 8'd0; leak_shift = 3'd0; spike_in = 4'b1111; mon_sel = 2'd3; en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step("sat_pos");
      e = (28 * (k - 1) > 255) ? 255 : 28 * (k - 1);
      check("sat_pos_v", {24'd0, v_mon}, e);
    end
    mon_sel = 2'd2;
    step("sat_neg");
    check("sat_neg_v", {24'd0, v_mon}, 32'd0);

    // Write and step in the same cycle: the step sees the old weight
    do_reset();
    wr(0, 2);
    threshold = 8'd0; spike_in = 4'b0001; mon_sel = 2'd0; en = 1'b1;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 4'd6;
    step("coll1");
    cfg_we = 1'b0;
    step("coll2");
    check("coll_old_w", {24'd0, v_mon}, 32'd2);
    step("coll3");
    check("coll_new_w", {24'd0, v_mon}, 32'd8);

    // Enable low holds state and suppresses spikes
    do_reset();
    wr(0, 7);
    threshold = 8'd0; spike_in = 4'b0001; mon_sel = 2'd0; en = 1'b1;
    step("hold_load");
    threshold = 8'd1; spike_in = 4'b1111; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("hold");
      check("hold_v", {24'd0, v_mon}, 32'd7);
      check("hold_spike", {28'd0, spike_out}, 32'd0);
    end

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < N*I; k++) wr(k, $urandom_range(0, 9));
    threshold = 8'($urandom_range(1, 40));
    for (int c = 0; c < 500; c++) begin
      en         = ($urandom_range(0, 3) != 0);
      spike_in   = 4'($urandom);
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_addr   = 4'($urandom);
      cfg_wdata  = 4'($urandom);
      leak_shift = 3'($urandom);
      mon_sel    = 2'($urandom);
      if ($urandom_range(0, 15) == 0) threshold = 8'($urandom_range(0, 60));
      step("rnd");
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    cfg_we = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
